// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg : shared constants and occupancy state type for fifo_read_adapter
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int SKID_DEPTH    = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_read_adapter_skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2 : two-entry in-order holding buffer; entry 0 is always the head
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output occ_state_e       state,
  output logic             valid
);

  occ_state_e       state_q, state_d;
  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    do_pop  = pop && (state_q != EMPTY);
    // A full buffer only accepts a push when the head leaves in the same cycle
    do_push = push && ((state_q != TWO) || do_pop);

    case (state_q)
      EMPTY: begin
        if (do_push) begin
          ent0_d  = push_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (do_push && do_pop) begin
          ent0_d = push_data;
        end else if (do_push) begin
          ent1_d  = push_data;
          state_d = TWO;
        end else if (do_pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (do_pop) begin
          ent0_d = ent1_q;
          if (do_push) begin
            ent1_d = push_data;
          end else begin
            state_d = ONE;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  assign head_data = ent0_q;
  assign state     = state_q;
  assign valid     = (state_q != EMPTY);

endmodule

`default_nettype wire

// File: rtl/fifo_read_adapter.sv
// ---------------------------------------------------------------------------
// fifo_read_adapter : turns a synchronous FIFO read port into valid/ready.
// Optional macro FIFO_READ_ADAPTER_CNT_EN adds the wordCount transfer counter.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_read_adapter #(
  parameter int WIDTH      = fifo_pkg::WIDTH_DEFAULT,
  parameter int SKID_DEPTH = fifo_pkg::SKID_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifoEmpty,
  input  logic [WIDTH-1:0] fifoData,
  output logic             fifoRdEn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
`ifdef FIFO_READ_ADAPTER_CNT_EN
  ,
  output logic [15:0]      wordCount
`endif
);

  import fifo_pkg::*;

  generate
    if (SKID_DEPTH != 2) begin : g_bad_depth
      $error("fifo_read_adapter: SKID_DEPTH must be 2");
    end
  endgenerate

  occ_state_e       occ;
  logic             buf_valid;
  logic [WIDTH-1:0] head_data;
  logic             in_flight_q, in_flight_d;
  logic             xfer;
  logic [2:0]       load;

  // Words held plus the one returning, less the one leaving, must stay below 2
  always_comb begin
    xfer        = outValid && outReady;
    load        = {1'b0, occ} + {2'b00, in_flight_q} - {2'b00, xfer};
    fifoRdEn    = !fifoEmpty && !rst && (load < 3'd2);
    in_flight_d = fifoRdEn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
    end
  end

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight_q),
    .push_data (fifoData),
    .pop       (xfer),
    .head_data (head_data),
    .state     (occ),
    .valid     (buf_valid)
  );

  assign outValid = buf_valid && !rst;
  assign outData  = rst ? '0 : head_data;

`ifdef FIFO_READ_ADAPTER_CNT_EN
  logic [15:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q + {15'd0, xfer};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_q <= 16'd0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign wordCount = word_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_adapter.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_adapter : adapter fed by an 8x8 synchronous FIFO model
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_read_adapter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifoEmpty;
  logic [7:0] fifoData = 8'h00;
  logic       fifoRdEn;
  logic       outValid;
  logic       outReady = 1'b0;
  logic [7:0] outData;
`ifdef FIFO_READ_ADAPTER_CNT_EN
  logic [15:0] wordCount;
`endif

  always #5 clk = ~clk;

  fifo_read_adapter #(.WIDTH(8), .SKID_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifoEmpty (fifoEmpty),
    .fifoData  (fifoData),
    .fifoRdEn  (fifoRdEn),
    .outValid  (outValid),
    .outReady  (outReady),
    .outData   (outData)
`ifdef FIFO_READ_ADAPTER_CNT_EN
    ,
    .wordCount (wordCount)
`endif
  );

  // Synchronous FIFO, DEPTH=8 WIDTH=8, registered read data
  logic [7:0] mem [8];
  logic [2:0] wr_ptr = 3'd0;
  logic [2:0] rd_ptr = 3'd0;
  logic [3:0] count = 4'd0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;

  assign fifoEmpty = (count == 4'd0);

  always @(posedge clk) begin
    if (flush) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (wr_en && count != 4'd8) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 3'd1;
      end
      if (fifoRdEn && count != 4'd0) begin
        fifoData <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 3'd1;
      end
      count <= count + {3'd0, (wr_en && count != 4'd8)} - {3'd0, (fifoRdEn && count != 4'd0)};
    end
  end

  // Scoreboard: words in FIFO read order; reset discards anything not yet delivered
  logic [7:0] exp_q [$];
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (fifoRdEn && count != 4'd0) exp_q.push_back(mem[rd_ptr]);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_cnt = 0;
  int rd_cnt = 0;
  int rd_on_empty = 0;
  logic [7:0] last_xfer = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (outValid && outReady) begin
      xfer_cnt++;
      last_xfer = outData;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_order: got %0h expected no transfer", outData);
      end else begin
        check("sb_order", {24'd0, outData}, {24'd0, exp_q.pop_front()});
      end
    end
    if (fifoRdEn) rd_cnt++;
    if (fifoRdEn && fifoEmpty) rd_on_empty++;
  end

  // Reset, empty the FIFO, write n words base+i under reset, release reset.
  // Returns at the negedge of cycle 0 after release.
  task automatic preload(input int n, input logic [7:0] base, input bit check_rst);
    @(negedge clk);
    rst   = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    if (check_rst) begin
      #1;
      check("rst_rden",  {31'd0, fifoRdEn}, 32'd0);
      check("rst_valid", {31'd0, outValid}, 32'd0);
      check("rst_data",  {24'd0, outData},  32'd0);
    end
    rst = 1'b0;
  endtask

  typedef struct {
    bit         start;
    bit         ready;
    bit         exp_rd;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [$];

  initial begin
    // Streaming: 8 words, outReady=1; reads cycles 0..7, data 0..7 in cycles 2..9
    for (int k = 0; k < 12; k++)
      vecs.push_back('{k == 0, 1'b1, k < 8, (k >= 2 && k < 10), 8'(k - 2)});
    // Backpressure: outReady=0 for 10 cycles -> two reads, head 0 held; then 0..7 gap-free
    for (int k = 0; k < 20; k++)
      vecs.push_back('{k == 0, k >= 10, (k < 2) || (k >= 10 && k < 16),
                       (k >= 2 && k < 18), (k < 10) ? 8'd0 : 8'(k - 10)});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].start) preload(8, 8'h00, i == 0);
      else @(negedge clk);
      outReady = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_rden", i),  {31'd0, fifoRdEn}, {31'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_valid", i), {31'd0, outValid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), {24'd0, outData}, {24'd0, vecs[i].exp_data});
    end

    // Toggling outReady: 8 transfers on even cycles 2..16
    preload(8, 8'h40, 1'b0);
    xfer_cnt = 0;
    rd_cnt   = 0;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      outReady = (k % 2 == 0);
    end
    @(negedge clk);
    outReady = 1'b0;
    #3;
    check("toggle_xfers", xfer_cnt, 32'd8);
    check("toggle_reads", rd_cnt, 32'd8);

    // Single word written into an empty FIFO
    @(negedge clk);
    rst   = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    rst      = 1'b0;
    outReady = 1'b1;
    xfer_cnt = 0;
    rd_cnt   = 0;
    repeat (5) @(negedge clk);
    #3;
    check("empty_no_read", rd_cnt, 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (6) @(negedge clk);
    #3;
    check("single_reads", rd_cnt, 32'd1);
    check("single_xfers", xfer_cnt, 32'd1);
    check("single_data", {24'd0, last_xfer}, 32'hA5);

    // Reset with one word held and one in flight
    preload(8, 8'h10, 1'b0);
    outReady = 1'b0;
    #1;
    check("rr_c0_rden", {31'd0, fifoRdEn}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rr_c2_valid", {31'd0, outValid}, 32'd1);
    check("rr_c2_data",  {24'd0, outData},  32'h10);
    rst = 1'b1;
    #1;
    check("rr_rst_valid", {31'd0, outValid}, 32'd0);
    check("rr_rst_data",  {24'd0, outData},  32'd0);
    @(negedge clk);
    rst      = 1'b0;
    outReady = 1'b1;
    #1;
    check("rr_c3_valid", {31'd0, outValid}, 32'd0);
    check("rr_c3_rden",  {31'd0, fifoRdEn}, 32'd1);
    @(negedge clk);
    #1;
    check("rr_c4_valid", {31'd0, outValid}, 32'd0);
    @(negedge clk);
    #1;
    check("rr_c5_valid", {31'd0, outValid}, 32'd1);
    check("rr_c5_data",  {24'd0, outData},  32'h12);
    repeat (10) @(negedge clk);

`ifdef FIFO_READ_ADAPTER_CNT_EN
    preload(8, 8'h20, 1'b0);
    outReady = 1'b0;
    #1;
    check("cnt_reset", {16'd0, wordCount}, 32'd0);
    force dut.word_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.word_count_q;
    @(negedge clk);
    outReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    outReady = 1'b0;
    @(negedge clk);
    #1;
    check("cnt_wrap", {16'd0, wordCount}, 32'h0001);
    repeat (3) @(negedge clk);
`endif

    #3;
    check("read_on_empty", rd_on_empty, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_read_adapter.md
FIFO_READ_ADAPTER -- requirements
Module: fifo_read_adapter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter SKID_DEPTH, fixed 2, entries in the internal holding buffer; no other value is legal.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 fifoEmpty  input  1  empty flag from the upstream synchronous FIFO.
REQ-006 fifoData  input  WIDTH  FIFO read data, valid in the cycle after a cycle with fifoRdEn=1 and fifoEmpty=0.
REQ-007 fifoRdEn  output  1  read strobe to the FIFO.
REQ-008 outValid  output  1  downstream data valid.
REQ-009 outReady  input  1  downstream accept; a transfer occurs when outValid=1 and outReady=1.
REQ-010 outData  output  WIDTH  downstream data, stable while outValid=1 and outReady=0.

Function
REQ-011 Occupancy state machine: EMPTY (0 held), ONE (1 held), TWO (2 held); transitions occur only on capture (+1) and downstream transfer (-1), and a simultaneous capture and transfer leaves the state unchanged.
REQ-012 inFlight flag: set in the cycle after fifoRdEn=1 with fifoEmpty=0; the returning word is captured at the end of that cycle.
REQ-013 fifoRdEn is combinational: asserted only when fifoEmpty=0, rst=0, and occupancy + inFlight - (outValid and outReady) < 2.
REQ-014 Throughput: with the FIFO non-empty and outReady held at 1, one word transfers per cycle after the first word.
REQ-015 Latency: fifoRdEn asserted in cycle N gives outValid=1 in cycle N+2 with outData equal to that word; no combinational path from fifoData to outData.
REQ-016 Ordering: words leave strictly in FIFO read order; none dropped or duplicated.
REQ-017 outValid equals (state != EMPTY); outData is the oldest held word.
REQ-018 Backpressure: with outReady=0 and state TWO, fifoRdEn stays 0 and the held words are preserved indefinitely.
REQ-019 fifoEmpty=1 blocks new reads; a word already in flight is still captured.
REQ-020 Words held in the buffer are unaffected by FIFO full/empty transitions.

Reset
REQ-021 While rst=1: fifoRdEn=0, outValid=0, state EMPTY, inFlight=0, outData=0.
REQ-022 Reset asserted with a word in flight or held discards that word; after rst deasserts, the first output word is the next word read from the FIFO.
REQ-023 In the first cycle after rst deasserts, fifoRdEn may assert if fifoEmpty=0.

Configuration
REQ-024 Macro FIFO_READ_ADAPTER_CNT_EN: when defined, add output wordCount (16 bits), incremented on every downstream transfer, wrapping 0xFFFF->0x0000, and cleared to 0 by rst.
REQ-025 Without FIFO_READ_ADAPTER_CNT_EN: no wordCount port and no counter logic; all other behaviour is identical.

Structure
REQ-026 Package fifo_pkg holds the WIDTH default constant, the SKID_DEPTH constant, and the occupancy state enum type (EMPTY/ONE/TWO).
REQ-027 Sub-module skid_buf2 implements the 2-entry holding buffer (push, pop, head data, occupancy); fifo_read_adapter contains the read-issue logic and the inFlight tracking.

Verification
REQ-028 Bench drives the adapter from the existing fifoSync (DEPTH=8, WIDTH=8) and checks every delivered word against a scoreboard in write order.
REQ-029 Write 0..7 into the FIFO, hold outReady=1 -> outData 0..7 on consecutive cycles, first outValid 2 cycles after the first fifoRdEn.
REQ-030 Write 0..7, hold outReady=0 for 10 cycles -> exactly 2 fifoRdEn pulses, state TWO, outData=0; then outReady=1 -> 0..7 in order with no gaps.
REQ-031 Toggle outReady 1/0 every cycle with the FIFO holding 8 words -> 8 transfers in 16 cycles, no loss and no duplicates.
REQ-032 Single word 0xA5 written while the FIFO is empty -> one fifoRdEn, outValid for exactly one transfer, no read issued on an empty FIFO.
REQ-033 Assert rst for 1 cycle with 1 word held and 1 in flight -> outValid=0 next cycle; the next delivered word is the third word written.
REQ-034 With FIFO_READ_ADAPTER_CNT_EN defined, preload wordCount near wrap (0xFFFE) via forced state, transfer 3 words -> wordCount reads 0x0001.
